fifo_wr_arbiter: RTL and testbench

//  Round-robin write arbiter sharing one syncfifo write port between N_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the mod-N pointer increment.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_st_t;

  // Increment a round-robin pointer, wrapping at n (n need not be a power of two).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first asserted request
// found when searching base, base+1, ... modulo N_REQ.
module fifo_wr_arbiter_rr_pick #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] base,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(base) + k) % N_REQ;
      if (!found && req[ID_WIDTH'(cand)]) begin
        found = 1'b1;
        idx   = ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one syncfifo write port between N_REQ producers.
// A grant is held for a whole packet, capped at MAX_BURST beats, and writes are gated by f_full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DT_WIDTH  = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*DT_WIDTH-1:0] req_dt,
  output logic [N_REQ-1:0]          req_rdy,
  input  logic                      f_full,
  output logic                      wrt_en,
  output logic [DT_WIDTH-1:0]       wrt_dt,
  output logic [ID_WIDTH-1:0]       gnt_id,
  output logic                      gnt_act
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  arb_st_t                st_q, st_d;
  logic [ID_WIDTH-1:0]    owner_q, owner_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0]       sel;
  logic                   pick_found;
  logic [ID_WIDTH-1:0]    pick_idx;

  fifo_wr_arbiter_rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req   (req_vld),
    .base  (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and one-hot beat select; nothing is accepted during reset or while full.
  always_comb begin
    st_d       = st_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    sel        = '0;
    if (!rst && !f_full) begin
      case (st_q)
        ARB_IDLE: begin
          if (pick_found) begin
            sel[pick_idx] = 1'b1;
            if (req_last[pick_idx] || (MAX_BURST == 1)) begin
              rr_ptr_d = ID_WIDTH'(rr_next(32'(pick_idx), N_REQ));
            end else begin
              st_d       = ARB_LOCKED;
              owner_d    = pick_idx;
              beat_cnt_d = CNT_WIDTH'(1);
            end
          end
        end
        ARB_LOCKED: begin
          // An owner gap just waits; only accepted beats advance the count.
          if (req_vld[owner_q]) begin
            sel[owner_q] = 1'b1;
            if (req_last[owner_q] || ((32'(beat_cnt_q) + 32'd1) == MAX_BURST)) begin
              st_d       = ARB_IDLE;
              rr_ptr_d   = ID_WIDTH'(rr_next(32'(owner_q), N_REQ));
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // AND-OR data mux; sel is one-hot or zero, so wrt_dt is zero when idle.
  always_comb begin
    wrt_dt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wrt_dt = wrt_dt | (req_dt[i*DT_WIDTH +: DT_WIDTH] & {DT_WIDTH{sel[i]}});
    end
  end

  assign req_rdy = sel;
  assign wrt_en  = |sel;
  assign gnt_act = (st_q == ARB_LOCKED);
  assign gnt_id  = gnt_act ? owner_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed the DUT and a scoreboard
// holds the predicted global order of FIFO writes (requester and data).
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_dt;
  logic [N-1:0]      req_rdy;
  logic              f_full;
  logic              wrt_en;
  logic [DW-1:0]     wrt_dt;
  logic [1:0]        gnt_id;
  logic              gnt_act;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DT_WIDTH  (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_last (req_last),
    .req_dt   (req_dt),
    .req_rdy  (req_rdy),
    .f_full   (f_full),
    .wrt_en   (wrt_en),
    .wrt_dt   (wrt_dt),
    .gnt_id   (gnt_id),
    .gnt_act  (gnt_act)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dt;
    logic       last;
  } beat_t;

  typedef struct {
    int         id;
    logic [7:0] dt;
  } exp_t;

  beat_t        src[N][$];
  exp_t         sb[$];
  logic [N-1:0] en;
  int           total = 0;
  int           bad = 0;
  logic [N-1:0] s_rdy;
  logic         s_we;
  logic [7:0]   s_dt;
  int           n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int id, input logic [7:0] dt, input logic last);
    beat_t b;
    b.dt   = dt;
    b.last = last;
    src[id].push_back(b);
  endtask

  task automatic expect_wr(input int id, input logic [7:0] dt);
    exp_t e;
    e.id = id;
    e.dt = dt;
    sb.push_back(e);
  endtask

  task automatic gnt(input string tag, input logic act, input logic [1:0] id);
    check({tag, "_act"}, 32'(gnt_act), 32'(act));
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
  endtask

  // One clock: drive producers, sample at negedge, score writes, retire accepted beats.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (en[i] && src[i].size() > 0) begin
        req_vld[i]            = 1'b1;
        req_last[i]           = src[i][0].last;
        req_dt[i*DW +: DW]    = src[i][0].dt;
      end else begin
        req_vld[i]            = 1'b0;
        req_last[i]           = 1'b0;
        req_dt[i*DW +: DW]    = '0;
      end
    end
    @(negedge clk);
    s_rdy = req_rdy;
    s_we  = wrt_en;
    s_dt  = wrt_dt;
    if (s_we) begin
      check("wr_has_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_rdy", 32'(s_rdy), 32'(1) << e.id);
        check("wr_data", 32'(s_dt), 32'(e.dt));
      end
    end else begin
      check("idle_rdy", 32'(s_rdy), 32'd0);
      check("idle_dt", 32'(s_dt), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      if (s_rdy[i] && src[i].size() > 0) void'(src[i].pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max, output int cnt);
    cnt = 0;
    while (sb.size() > 0 && cnt < max) begin
      cycle();
      cnt++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    f_full   = 1'b0;
    en       = '1;
    req_vld  = '1;
    req_last = '1;
    req_dt   = {N*DW{1'b1}};

    // Reset with every requester valid: nothing may be granted.
    repeat (2) begin
      @(negedge clk);
      check("rst_rdy", 32'(req_rdy), 32'd0);
      check("rst_we", 32'(wrt_en), 32'd0);
      check("rst_dt", 32'(wrt_dt), 32'd0);
      check("rst_gnt_act", 32'(gnt_act), 32'd0);
      check("rst_gnt_id", 32'(gnt_id), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single-beat packets from everyone, two rounds, one write per cycle.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        load(i, {4'(i), 4'(k + 1)}, 1'b1);
        expect_wr(i, {4'(i), 4'(k + 1)});
      end
    end
    drain("s1", 20, n);
    check("s1_cycles", 32'(n), 32'd8);
    gnt("s1_end", 1'b0, 2'd0);

    // 2: req1 three-beat packet holds off req2 (pointer is back at 0).
    load(1, 8'h1a, 1'b0);
    load(1, 8'h1b, 1'b0);
    load(1, 8'h1c, 1'b1);
    load(2, 8'h2a, 1'b1);
    expect_wr(1, 8'h1a);
    expect_wr(1, 8'h1b);
    expect_wr(1, 8'h1c);
    expect_wr(2, 8'h2a);
    cycle();
    gnt("s2_lock", 1'b1, 2'd1);
    drain("s2", 10, n);
    check("s2_cycles", 32'(n), 32'd3);

    // 3: six-beat packet from req0 is split at four beats; req1 slips in between.
    for (int k = 1; k <= 6; k++) load(0, 8'(k), (k == 6));
    load(1, 8'h1d, 1'b1);
    for (int k = 1; k <= 4; k++) expect_wr(0, 8'(k));
    expect_wr(1, 8'h1d);
    expect_wr(0, 8'h05);
    expect_wr(0, 8'h06);
    repeat (3) cycle();
    gnt("s3_locked", 1'b1, 2'd0);
    cycle();
    gnt("s3_forced_release", 1'b0, 2'd0);
    drain("s3", 10, n);
    check("s3_cycles", 32'(n), 32'd3);

    // 4: FIFO full for three cycles mid-burst; count must freeze.
    for (int k = 1; k <= 4; k++) load(2, 8'h20 + 8'(k), (k == 4));
    load(3, 8'h3f, 1'b1);
    for (int k = 1; k <= 4; k++) expect_wr(2, 8'h20 + 8'(k));
    expect_wr(3, 8'h3f);
    cycle();
    cycle();
    f_full = 1'b1;
    repeat (3) begin
      cycle();
      check("s4_full_we", 32'(s_we), 32'd0);
      gnt("s4_full", 1'b1, 2'd2);
    end
    f_full = 1'b0;
    drain("s4", 10, n);
    check("s4_cycles", 32'(n), 32'd3);

    // 5: owner gap of two cycles; req3 must wait for the last beat.
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b0);
    load(1, 8'h13, 1'b1);
    load(3, 8'h3e, 1'b1);
    expect_wr(1, 8'h11);
    expect_wr(1, 8'h12);
    expect_wr(1, 8'h13);
    expect_wr(3, 8'h3e);
    cycle();
    en[1] = 1'b0;
    repeat (2) begin
      cycle();
      check("s5_hold_we", 32'(s_we), 32'd0);
      gnt("s5_hold", 1'b1, 2'd1);
    end
    en[1] = 1'b1;
    drain("s5", 10, n);
    check("s5_cycles", 32'(n), 32'd3);

    // 6: reset after beat 2 of req3's burst; req1 then wins from pointer 0.
    load(3, 8'h31, 1'b0);
    load(3, 8'h32, 1'b0);
    load(3, 8'h33, 1'b1);
    expect_wr(3, 8'h31);
    expect_wr(3, 8'h32);
    cycle();
    cycle();
    gnt("s6_pre", 1'b1, 2'd3);
    load(1, 8'h1e, 1'b1);
    expect_wr(1, 8'h1e);
    expect_wr(3, 8'h33);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    gnt("s6_post_rst", 1'b0, 2'd0);
    drain("s6", 10, n);
    check("s6_cycles", 32'(n), 32'd2);

    repeat (3) cycle();
    gnt("final", 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
